preamble_serial_tx: RTL and testbench
=====================================

// Module: preamble_serial_tx
// PURPOSE
//  Bit-serial frame transmitter; the sending end of the serial line our sequence detectors watch.
//  Accepts one parallel word per valid/ready handshake. Emits a fixed preamble (default 1001),
//  then the word MSB-first, then an idle gap. All outputs registered, so the line is glitch-free.
// PARAMETERS
//  DATA_W    8        payload bits per frame (>=1)
//  PRE_W     4        preamble length in bits (>=1)
//  PREAMBLE  4'b1001  preamble pattern, sent MSB-first
//  GAP_CYC   2        idle cycles after the last data bit (0 allowed: GAP state skipped)
// PORTS
//  clk        in   1       single clock; all logic on posedge
//  rst        in   1       synchronous, active-high reset
//  in_data    in   DATA_W  word to send; sampled only on accept
//  in_valid   in   1       word available
//  in_ready   out  1       block idle, can accept (registered)
//  out        out  1       serial line bit (registered)
//  out_valid  out  1       high while a preamble or data bit is on out
//  out_last   out  1       high with the final data bit of the frame
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, out=0, out_valid=0, out_last=0, busy=0, in_ready=1.
//   Reset wins over everything. A frame in flight is aborted with no partial data and no out_last.
//  FSM states (in package): IDLE -> PRE -> DATA -> GAP -> IDLE.
//   IDLE: in_ready=1, out=0. On in_valid&&in_ready at edge k: capture in_data into the shift
//     register, load the preamble, counter=PRE_W-1, go to PRE. in_ready goes 0 at edge k.
//   PRE: cycles k+1..k+PRE_W. out = PREAMBLE[PRE_W-1 .. 0], one bit per cycle, out_valid=1.
//   DATA: next DATA_W cycles. out = data[DATA_W-1 .. 0], out_valid=1. out_last=1 on bit 0 only.
//   GAP: GAP_CYC cycles with out=0, out_valid=0. Then IDLE; in_ready=1 from the next cycle.
//  Latency: the first preamble bit appears the cycle after accept.
//   Minimum frame period = 1 + PRE_W + DATA_W + GAP_CYC cycles, with one mandatory IDLE cycle.
//  in_valid while not ready: ignored, nothing captured. in_data changes mid-frame have no effect.
//  Counter: one down-counter, width $clog2(max(PRE_W,DATA_W,GAP_CYC)+1). It reloads on each
//   state change, and the state advances at count 0. No wrap-around beyond reload.
//  Payload is not checked for embedded preamble patterns. Receiver framing handles that.
//  Outside PRE/DATA: out=0, out_valid=0, out_last=0. Illegal state encodings go to IDLE.
// STRUCTURE
//  Package serial_tx_pkg: state typedef/encodings (IDLE, PRE, DATA, GAP), default PREAMBLE constant.
//  Three always blocks: state register, next-state combinational, registered outputs.
//  One sub-module: piso_shift_reg (parallel load, shift left, MSB out; width param),
//   used for the payload.
// TESTING
//  1 Reset: hold rst with in_valid=1 -> in_ready=1, out=0, out_valid=0, busy=0; nothing accepted.
//  2 Single frame, in_data=8'hA5 -> out = 1,0,0,1, 1,0,1,0,0,1,0,1 on the 12 cycles after accept.
//    out_valid=1 on all 12, out_last=1 on the 12th only, then 2 gap cycles, then in_ready=1.
//  3 Back-to-back 8'h00 then 8'hFF, in_valid held high -> second accept exactly 15 cycles after
//    the first. Streams are 1001_00000000 and 1001_11111111.
//  4 in_valid pulsed and in_data changed during a frame -> ignored; the frame payload is unchanged.
//  5 rst asserted in the 3rd data bit -> next cycle out=0, out_valid=0, in_ready=1, no out_last.
//    The next accepted frame is complete and correct.
//  6 Parameter sweep DATA_W=1, PRE_W=1, GAP_CYC=0 -> frame = 1 preamble bit + 1 data bit.
//    out_last is on the data bit; period is 3 cycles.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the preamble serial transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1001;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: load a word, shift left, MSB presented on msb.
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/preamble_serial_tx.sv
// Bit-serial frame transmitter: preamble, then payload MSB-first, then an idle gap.
// Outputs are registered from the next-state values so the line never glitches.
module preamble_serial_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       PRE_W    = 4,
    parameter logic [PRE_W-1:0]  PREAMBLE = PRE_W'(DEFAULT_PREAMBLE),
    parameter int unsigned       GAP_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned CNT_MAX = max3(PRE_W, DATA_W, GAP_CYC);
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned GAP_LD  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             accept;
    logic             data_msb;
    logic [PRE_W-1:0] pre_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                accept = in_valid && in_ready;
                if (accept) begin
                    state_next = PRE;
                    cnt_next   = CW'(PRE_W - 1);
                end
            end
            PRE: begin
                if (cnt == '0) begin
                    state_next = DATA;
                    cnt_next   = CW'(DATA_W - 1);
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    if (GAP_CYC == 0) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = GAP;
                        cnt_next   = CW'(GAP_LD);
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    piso_shift_reg #(
        .WIDTH(DATA_W)
    ) u_payload (
        .clk  (clk),
        .load (accept),
        .shift(state_next == DATA),
        .din  (in_data),
        .msb  (data_msb)
    );

    // The first preamble bit goes out on the accept edge itself, so the
    // preamble register is loaded pre-shifted and the MSB comes from PREAMBLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            case (state_next)
                PRE: begin
                    out       <= accept ? PREAMBLE[PRE_W-1] : pre_sr[PRE_W-1];
                    out_valid <= 1'b1;
                end
                DATA: begin
                    out       <= data_msb;
                    out_valid <= 1'b1;
                    out_last  <= (cnt_next == '0);
                end
                default: ;
            endcase
            busy     <= (state_next != IDLE);
            in_ready <= (state_next == IDLE);
            if (accept) begin
                pre_sr <= PREAMBLE << 1;
            end else if (state_next == PRE) begin
                pre_sr <= pre_sr << 1;
            end
        end
    end

endmodule

// File: tb/tb_preamble_serial_tx.sv
// Self-checking bench: frame-level queue model checked every cycle, plus literal stream checks.
module tb_preamble_serial_tx;

    localparam int          DW1  = 8;
    localparam int          PW1  = 4;
    localparam int          GAP1 = 2;
    localparam logic [3:0]  PRE1 = 4'b1001;
    localparam int          DW2  = 1;
    localparam int          PW2  = 1;
    localparam int          GAP2 = 0;
    localparam logic [0:0]  PRE2 = 1'b1;
    localparam logic [4:0]  IDLE_E = 5'b00010; // {out, valid, last, ready, busy}

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d1  = '0;
    logic       v1  = 1'b0;
    logic [0:0] d2  = '0;
    logic       v2  = 1'b0;
    logic       o1, ov1, ol1, rdy1, busy1;
    logic       o2, ov2, ol2, rdy2, busy2;

    always #5 clk = ~clk;

    preamble_serial_tx u_dut1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
        .out(o1), .out_valid(ov1), .out_last(ol1), .busy(busy1)
    );

    preamble_serial_tx #(
        .DATA_W(DW2), .PRE_W(PW2), .PREAMBLE(PRE2), .GAP_CYC(GAP2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(rdy2),
        .out(o2), .out_valid(ov2), .out_last(ol2), .busy(busy2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: on accept, the whole frame's per-cycle outputs are queued up front.
    logic [4:0] cur1 = IDLE_E;
    logic [4:0] cur2 = IDLE_E;
    logic [4:0] q1[$];
    logic [4:0] q2[$];
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q1.delete();
            q2.delete();
            cur1   = IDLE_E;
            cur2   = IDLE_E;
            chk_en = 1'b1;
        end else begin
            if (cur1[1] && v1) begin
                for (int i = 0; i < PW1; i++) q1.push_back({PRE1[PW1-1-i], 4'b1001});
                for (int i = 0; i < DW1; i++)
                    q1.push_back({d1[DW1-1-i], 1'b1, (i == DW1-1), 2'b01});
                for (int i = 0; i < GAP1; i++) q1.push_back(5'b00001);
            end
            if (cur2[1] && v2) begin
                for (int i = 0; i < PW2; i++) q2.push_back({PRE2[PW2-1-i], 4'b1001});
                for (int i = 0; i < DW2; i++)
                    q2.push_back({d2[DW2-1-i], 1'b1, (i == DW2-1), 2'b01});
                for (int i = 0; i < GAP2; i++) q2.push_back(5'b00001);
            end
            cur1 = (q1.size() > 0) ? q1.pop_front() : IDLE_E;
            cur2 = (q2.size() > 0) ? q2.pop_front() : IDLE_E;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("dut1_cycle", {27'd0, o1, ov1, ol1, rdy1, busy1}, {27'd0, cur1});
            check("dut2_cycle", {27'd0, o2, ov2, ol2, rdy2, busy2}, {27'd0, cur2});
        end
    end

    // Stream capture and handshake timestamps for the literal checks.
    logic [31:0] cap1 = '0;
    logic [31:0] cap2 = '0;
    int cap1_n = 0, last1_at = 0, cap2_n = 0, last2_n = 0;
    int cyc = 0, hs1_n = 0, hs2_n = 0;
    int hs1[16];
    int hs2[16];

    always @(negedge clk) begin
        if (ov1) begin
            cap1 = {cap1[30:0], o1};
            cap1_n++;
            if (ol1) last1_at = cap1_n;
        end
        if (ov2) begin
            cap2 = {cap2[30:0], o2};
            cap2_n++;
            if (ol2) last2_n++;
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst && v1 && rdy1) begin
            hs1[hs1_n % 16] = cyc;
            hs1_n++;
        end
        if (!rst && v2 && rdy2) begin
            hs2[hs2_n % 16] = cyc;
            hs2_n++;
        end
    end

    task automatic clear1();
        cap1 = '0; cap1_n = 0; last1_at = 0;
    endtask

    task automatic wait_hs1(input int target, input int budget);
        int k = 0;
        while (hs1_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("hs1_wait", (hs1_n >= target), 1);
    endtask

    task automatic wait_hs2(input int target, input int budget);
        int k = 0;
        while (hs2_n < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("hs2_wait", (hs2_n >= target), 1);
    endtask

    initial begin
        int base;

        // Reset held with in_valid high: nothing accepted.
        rst = 1'b1; v1 = 1'b1; d1 = 8'hA5;
        repeat (3) @(negedge clk);
        check("rst_ready", rdy1, 1);
        check("rst_out", o1, 0);
        check("rst_valid", ov1, 0);
        check("rst_busy", busy1, 0);
        rst = 1'b0; v1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_no_accept", hs1_n, 0);
        check("rst_idle_busy", busy1, 0);

        // Single frame A5.
        clear1();
        d1 = 8'hA5; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        check("t2_latency", {ov1, o1}, 2'b11);
        repeat (13) @(negedge clk);
        check("t2_gap_ready", rdy1, 0);
        @(negedge clk);
        check("t2_ready", rdy1, 1);
        check("t2_stream", cap1[11:0], 12'h9A5);
        check("t2_nbits", cap1_n, 12);
        check("t2_last_pos", last1_at, 12);

        // Back-to-back 00 then FF with in_valid held.
        clear1();
        base = hs1_n;
        d1 = 8'h00; v1 = 1'b1;
        wait_hs1(base + 1, 5);
        d1 = 8'hFF;
        wait_hs1(base + 2, 30);
        v1 = 1'b0;
        repeat (16) @(negedge clk);
        check("t3_period", hs1[(base + 1) % 16] - hs1[base % 16], 15);
        check("t3_stream", cap1[23:0], 24'h9009FF);
        check("t3_nbits", cap1_n, 24);

        // in_valid pulses and in_data changes mid-frame are ignored.
        clear1();
        base = hs1_n;
        d1 = 8'h3C; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        repeat (3) @(negedge clk);
        d1 = 8'hFF; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0; d1 = 8'h00;
        repeat (2) @(negedge clk);
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_one_accept", hs1_n - base, 1);
        check("t4_stream", cap1[11:0], 12'h93C);
        check("t4_nbits", cap1_n, 12);

        // Reset during the third data bit aborts the frame.
        clear1();
        d1 = 8'hC3; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_out", o1, 0);
        check("t5_valid", ov1, 0);
        check("t5_ready", rdy1, 1);
        check("t5_busy", busy1, 0);
        check("t5_no_last", last1_at, 0);
        check("t5_partial_n", cap1_n, 7);
        check("t5_partial", cap1[6:0], 7'b1001110);
        rst = 1'b0;
        clear1();
        d1 = 8'h5A; v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        repeat (14) @(negedge clk);
        check("t5_after_stream", cap1[11:0], 12'h95A);
        check("t5_after_nbits", cap1_n, 12);
        check("t5_after_last", last1_at, 12);

        // Minimal configuration: 1 preamble bit, 1 data bit, no gap.
        cap2 = '0; cap2_n = 0; last2_n = 0;
        base = hs2_n;
        d2 = 1'b0; v2 = 1'b1;
        wait_hs2(base + 1, 5);
        d2 = 1'b1;
        wait_hs2(base + 2, 10);
        v2 = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_period", hs2[(base + 1) % 16] - hs2[base % 16], 3);
        check("t6_stream", cap2[3:0], 4'b1011);
        check("t6_nbits", cap2_n, 4);
        check("t6_lasts", last2_n, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
